// File: rtl/fetch2_pkg.sv
// Shared configuration, control-transfer encodings and FIFO entry layout for fetch stage 2.
// Resize the block by editing the configuration localparams here.
package fetch2_pkg;

  localparam int FETCH_WIDTH      = 4;
  localparam int SIZE_PC          = 32;
  localparam int SIZE_INSTRUCTION = 64;
  localparam int QDEPTH           = 4;
  localparam int INST_STRIDE      = 8;

  localparam int SLOT_W = $clog2(FETCH_WIDTH);
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    CT_RTR  = 2'b00,
    CT_CALL = 2'b01,
    CT_JUMP = 2'b10,
    CT_COND = 2'b11
  } ctrlType_e;

  typedef struct packed {
    logic [SIZE_PC-1:0]                       pc;
    logic [FETCH_WIDTH*SIZE_INSTRUCTION-1:0]  bundle;
    logic [FETCH_WIDTH*SIZE_PC-1:0]           targets;
    logic [FETCH_WIDTH-1:0]                   preds;
    logic [FETCH_WIDTH-1:0]                   mask;
  } fifoEntry_t;

  // PC of a slot within a bundle; wraps modulo 2^SIZE_PC.
  function automatic logic [SIZE_PC-1:0] slotPc(input logic [SIZE_PC-1:0] base,
                                                input logic [SLOT_W-1:0]  slot);
    return base + SIZE_PC'(slot) * SIZE_PC'(INST_STRIDE);
  endfunction

endpackage

// File: rtl/fetch2_bundle_queue_if.sv
// Bundle-in / redirect-out / bundle-out signal group of fetch stage 2.
// Handshakes: a transfer happens on a clock edge where valid and ready are both high;
// valid never depends on ready, and ready (fs1_ready_o) comes from registered state only.
interface fetch2_bundle_queue_if;
  import fetch2_pkg::*;

  logic                                   flush_i;
  logic                                   fs1_valid_i;
  logic                                   fs1_ready_o;
  logic [SIZE_PC-1:0]                     pc_i;
  logic [SLOT_W-1:0]                      start_slot_i;
  logic [FETCH_WIDTH*SIZE_INSTRUCTION-1:0] bundle_i;
  logic [FETCH_WIDTH-1:0]                 is_ctrl_i;
  logic [2*FETCH_WIDTH-1:0]               ctrl_type_i;
  logic [FETCH_WIDTH-1:0]                 pred_taken_i;
  logic [FETCH_WIDTH-1:0]                 btb_hit_i;
  logic [FETCH_WIDTH*SIZE_PC-1:0]         pd_target_i;
  logic [SIZE_PC-1:0]                     ras_top_i;
  logic                                   redirect_o;
  logic [SIZE_PC-1:0]                     redirect_pc_o;
  logic                                   redirect_call_o;
  logic                                   redirect_rtr_o;
  logic [SIZE_PC-1:0]                     call_pc_o;
  logic                                   out_valid_o;
  logic                                   out_ready_i;
  logic [SIZE_PC-1:0]                     out_pc_o;
  logic [FETCH_WIDTH*SIZE_INSTRUCTION-1:0] out_bundle_o;
  logic [FETCH_WIDTH*SIZE_PC-1:0]         out_target_o;
  logic [FETCH_WIDTH-1:0]                 out_pred_o;
  logic [FETCH_WIDTH-1:0]                 out_mask_o;
  logic [CNT_W-1:0]                       occupancy_o;

  modport slave (
    input  flush_i, fs1_valid_i, pc_i, start_slot_i, bundle_i, is_ctrl_i, ctrl_type_i,
           pred_taken_i, btb_hit_i, pd_target_i, ras_top_i, out_ready_i,
    output fs1_ready_o, redirect_o, redirect_pc_o, redirect_call_o, redirect_rtr_o, call_pc_o,
           out_valid_o, out_pc_o, out_bundle_o, out_target_o, out_pred_o, out_mask_o, occupancy_o
  );

  modport master (
    output flush_i, fs1_valid_i, pc_i, start_slot_i, bundle_i, is_ctrl_i, ctrl_type_i,
           pred_taken_i, btb_hit_i, pd_target_i, ras_top_i, out_ready_i,
    input  fs1_ready_o, redirect_o, redirect_pc_o, redirect_call_o, redirect_rtr_o, call_pc_o,
           out_valid_o, out_pc_o, out_bundle_o, out_target_o, out_pred_o, out_mask_o, occupancy_o
  );

endinterface

// File: rtl/fetch2_slot_select.sv
// Combinational slot filter: finds the first taken control transfer at or after the
// entry offset, builds the slot-valid mask and applies the RAS override to returns.
module fetch2_slot_select
  import fetch2_pkg::*;
(
  input  logic [SLOT_W-1:0]            startSlot,
  input  logic [FETCH_WIDTH-1:0]       isCtrl,
  input  logic [2*FETCH_WIDTH-1:0]     ctrlType,
  input  logic [FETCH_WIDTH-1:0]       predTaken,
  input  logic [FETCH_WIDTH-1:0]       btbHit,
  input  logic [FETCH_WIDTH*SIZE_PC-1:0] pdTarget,
  input  logic [SIZE_PC-1:0]           rasTop,
  output logic                         found,
  output logic [SLOT_W-1:0]            firstSlot,
  output logic [1:0]                   firstType,
  output logic                         firstBtbHit,
  output logic [SIZE_PC-1:0]           firstTarget,
  output logic [FETCH_WIDTH-1:0]       mask,
  output logic [FETCH_WIDTH*SIZE_PC-1:0] targets
);

  logic [FETCH_WIDTH-1:0] eligible;

  // A conditional predicted not-taken falls through and does not end the bundle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      eligible[i] = (SLOT_W'(i) >= startSlot) && isCtrl[i] &&
                    ((ctrlType[2*i +: 2] != CT_COND) || predTaken[i]);
    end
  end

  always_comb begin
    found     = 1'b0;
    firstSlot = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found     = 1'b1;
        firstSlot = SLOT_W'(i);
      end
    end
  end

  assign firstType   = ctrlType[{firstSlot, 1'b0} +: 2];
  assign firstBtbHit = btbHit[firstSlot];

  always_comb begin
    mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask[i] = (SLOT_W'(i) >= startSlot) && (!found || (SLOT_W'(i) <= firstSlot));
    end
    targets = pdTarget;
    if (found && (firstType == CT_RTR) && !firstBtbHit) begin
      targets[firstSlot*SIZE_PC +: SIZE_PC] = rasTop;
    end
    firstTarget = targets[firstSlot*SIZE_PC +: SIZE_PC];
  end

endmodule

// File: rtl/fetch2_bundle_queue.sv
// Fetch stage 2: filters FS1 bundles, raises registered BTB-miss redirects and
// buffers filtered bundles in a first-word fall-through FIFO toward decode.
module fetch2_bundle_queue
  import fetch2_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fetch2_bundle_queue_if.slave fq
);

  fifoEntry_t                 mem [QDEPTH];
  logic [PTR_W-1:0]           wrPtr;
  logic [PTR_W-1:0]           rdPtr;
  logic [CNT_W-1:0]           count;

  logic                       redirect;
  logic [SIZE_PC-1:0]         redirectPc;
  logic [SIZE_PC-1:0]         callPc;
  logic                       redirectCall;
  logic                       redirectRtr;

  logic                       found;
  logic [SLOT_W-1:0]          firstSlot;
  logic [1:0]                 firstType;
  logic                       firstBtbHit;
  logic [SIZE_PC-1:0]         firstTarget;
  logic [FETCH_WIDTH-1:0]     selMask;
  logic [FETCH_WIDTH*SIZE_PC-1:0] selTargets;

  logic                       accept;
  logic                       pop;
  logic                       outValid;
  logic                       raise;
  fifoEntry_t                 newEntry;

  fetch2_slot_select u_select (
    .startSlot   (fq.start_slot_i),
    .isCtrl      (fq.is_ctrl_i),
    .ctrlType    (fq.ctrl_type_i),
    .predTaken   (fq.pred_taken_i),
    .btbHit      (fq.btb_hit_i),
    .pdTarget    (fq.pd_target_i),
    .rasTop      (fq.ras_top_i),
    .found       (found),
    .firstSlot   (firstSlot),
    .firstType   (firstType),
    .firstBtbHit (firstBtbHit),
    .firstTarget (firstTarget),
    .mask        (selMask),
    .targets     (selTargets)
  );

  assign fq.fs1_ready_o = count < CNT_W'(QDEPTH);
  // A bundle presented while a redirect is out is wrong-path and is dropped.
  assign accept   = fq.fs1_valid_i & fq.fs1_ready_o & ~fq.flush_i & ~redirect;
  assign outValid = (count != '0);
  assign pop      = outValid & fq.out_ready_i;
  assign raise    = accept & found & ~firstBtbHit;

  assign newEntry = '{pc: fq.pc_i, bundle: fq.bundle_i, targets: selTargets,
                      preds: fq.pred_taken_i, mask: selMask};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (fq.flush_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        mem[wrPtr] <= newEntry;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Redirect fields are zero whenever no redirect is being signalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect     <= 1'b0;
      redirectPc   <= '0;
      callPc       <= '0;
      redirectCall <= 1'b0;
      redirectRtr  <= 1'b0;
    end else if (fq.flush_i) begin
      redirect     <= 1'b0;
      redirectPc   <= '0;
      callPc       <= '0;
      redirectCall <= 1'b0;
      redirectRtr  <= 1'b0;
    end else begin
      redirect     <= raise;
      redirectPc   <= raise ? firstTarget : '0;
      callPc       <= raise ? slotPc(fq.pc_i, firstSlot) : '0;
      redirectCall <= raise && (firstType == CT_CALL);
      redirectRtr  <= raise && (firstType == CT_RTR);
    end
  end

  assign fq.redirect_o      = redirect;
  assign fq.redirect_pc_o   = redirectPc;
  assign fq.redirect_call_o = redirectCall;
  assign fq.redirect_rtr_o  = redirectRtr;
  assign fq.call_pc_o       = callPc;

  assign fq.out_valid_o  = outValid;
  assign fq.out_pc_o     = mem[rdPtr].pc;
  assign fq.out_bundle_o = mem[rdPtr].bundle;
  assign fq.out_target_o = mem[rdPtr].targets;
  assign fq.out_pred_o   = mem[rdPtr].preds;
  assign fq.out_mask_o   = outValid ? mem[rdPtr].mask : '0;
  assign fq.occupancy_o  = count;

endmodule

// File: tb/tb_fetch2_bundle_queue.sv
// Self-checking bench for fetch2_bundle_queue: directed cases followed by random traffic,
// all compared against a queue-based reference model.
module tb_fetch2_bundle_queue;
  import fetch2_pkg::*;

  localparam int ENTRY_W = $bits(fifoEntry_t);

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch2_bundle_queue_if fq ();
  fetch2_bundle_queue dut (.clk(clk), .reset(reset), .fq(fq));

  // scoreboard state
  int tests_run    = 0;
  int tests_failed = 0;
  logic [ENTRY_W-1:0] exp_q[$];
  logic               m_redir;
  logic               m_call;
  logic               m_rtr;
  logic [SIZE_PC-1:0] m_redir_pc;
  logic [SIZE_PC-1:0] m_call_pc;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_redir    = 1'b0;
    m_call     = 1'b0;
    m_rtr      = 1'b0;
    m_redir_pc = '0;
    m_call_pc  = '0;
  endtask

  // Reference filter: scan slots from the entry offset, stop at the first taken transfer.
  task automatic model_bundle(output fifoEntry_t e, output logic redir,
                              output logic [SIZE_PC-1:0] rpc, output logic rcall,
                              output logic rrtr, output logic [SIZE_PC-1:0] cpc);
    int f;
    int start;
    int last;
    logic [1:0] ty;
    f     = -1;
    start = int'(fq.start_slot_i);
    for (int i = start; i < FETCH_WIDTH; i++) begin
      ty = fq.ctrl_type_i[2*i +: 2];
      if (f < 0 && fq.is_ctrl_i[i] && (ty != 2'b11 || fq.pred_taken_i[i])) f = i;
    end
    last      = (f < 0) ? FETCH_WIDTH - 1 : f;
    e.pc      = fq.pc_i;
    e.bundle  = fq.bundle_i;
    e.targets = fq.pd_target_i;
    e.preds   = fq.pred_taken_i;
    e.mask    = FETCH_WIDTH'((1 << (last + 1)) - (1 << start));
    redir = 1'b0; rpc = '0; rcall = 1'b0; rrtr = 1'b0; cpc = '0;
    if (f >= 0) begin
      ty = fq.ctrl_type_i[2*f +: 2];
      if (ty == 2'b00 && !fq.btb_hit_i[f]) e.targets[f*SIZE_PC +: SIZE_PC] = fq.ras_top_i;
      if (!fq.btb_hit_i[f]) begin
        redir = 1'b1;
        rpc   = e.targets[f*SIZE_PC +: SIZE_PC];
        rcall = (ty == 2'b01);
        rrtr  = (ty == 2'b00);
        cpc   = fq.pc_i + SIZE_PC'(8 * f);
      end
    end
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model.
  task automatic step();
    fifoEntry_t h;
    fifoEntry_t e;
    logic acc, pp, r, rc, rr;
    logic [SIZE_PC-1:0] rp, cp;
    @(negedge clk);
    check_eq("fs1_ready", 256'(fq.fs1_ready_o), 256'(exp_q.size() < QDEPTH));
    check_eq("occupancy", 256'(fq.occupancy_o), 256'(exp_q.size()));
    check_eq("out_valid", 256'(fq.out_valid_o), 256'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check_eq("head_pc", 256'(fq.out_pc_o), 256'(h.pc));
      check_eq("head_bundle", 256'(fq.out_bundle_o), 256'(h.bundle));
      check_eq("head_target", 256'(fq.out_target_o), 256'(h.targets));
      check_eq("head_pred", 256'(fq.out_pred_o), 256'(h.preds));
      check_eq("head_mask", 256'(fq.out_mask_o), 256'(h.mask));
    end else begin
      check_eq("empty_mask", 256'(fq.out_mask_o), 256'(0));
    end
    check_eq("redirect", 256'(fq.redirect_o), 256'(m_redir));
    check_eq("redirect_pc", 256'(fq.redirect_pc_o), 256'(m_redir_pc));
    check_eq("redirect_call", 256'(fq.redirect_call_o), 256'(m_call));
    check_eq("redirect_rtr", 256'(fq.redirect_rtr_o), 256'(m_rtr));
    check_eq("call_pc", 256'(fq.call_pc_o), 256'(m_call_pc));

    model_bundle(e, r, rp, rc, rr, cp);
    acc = fq.fs1_valid_i && (exp_q.size() < QDEPTH) && !fq.flush_i && !m_redir;
    pp  = (exp_q.size() != 0) && fq.out_ready_i;
    if (fq.flush_i) begin
      model_clear();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
      m_redir    = acc && r;
      m_redir_pc = (acc && r) ? rp : '0;
      m_call     = acc && r && rc;
      m_rtr      = acc && r && rr;
      m_call_pc  = (acc && r) ? cp : '0;
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic idle();
    fq.flush_i      = 1'b0;
    fq.fs1_valid_i  = 1'b0;
    fq.pc_i         = '0;
    fq.start_slot_i = '0;
    fq.bundle_i     = '0;
    fq.is_ctrl_i    = '0;
    fq.ctrl_type_i  = '0;
    fq.pred_taken_i = '0;
    fq.btb_hit_i    = '0;
    fq.pd_target_i  = '0;
    fq.ras_top_i    = '0;
    fq.out_ready_i  = 1'b1;
  endtask

  task automatic drive_bundle(input logic [SIZE_PC-1:0] pc, input logic [SLOT_W-1:0] start,
                              input logic [FETCH_WIDTH-1:0] ctrl,
                              input logic [2*FETCH_WIDTH-1:0] ctype,
                              input logic [FETCH_WIDTH-1:0] pred,
                              input logic [FETCH_WIDTH-1:0] btb,
                              input logic [SIZE_PC-1:0] ras);
    fq.fs1_valid_i  = 1'b1;
    fq.pc_i         = pc;
    fq.start_slot_i = start;
    fq.is_ctrl_i    = ctrl;
    fq.ctrl_type_i  = ctype;
    fq.pred_taken_i = pred;
    fq.btb_hit_i    = btb;
    fq.ras_top_i    = ras;
    for (int i = 0; i < FETCH_WIDTH * SIZE_INSTRUCTION / 32; i++) fq.bundle_i[i*32 +: 32] = $urandom();
    for (int i = 0; i < FETCH_WIDTH; i++) fq.pd_target_i[i*SIZE_PC +: SIZE_PC] = SIZE_PC'($urandom());
  endtask

  task automatic drain();
    idle();
    repeat (QDEPTH + 1) step();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_clear();
    #3;
    check_eq("rst_fs1_ready", 256'(fq.fs1_ready_o), 256'(1));
    check_eq("rst_out_valid", 256'(fq.out_valid_o), 256'(0));
    check_eq("rst_occupancy", 256'(fq.occupancy_o), 256'(0));
    check_eq("rst_redirect", 256'(fq.redirect_o), 256'(0));
    check_eq("rst_out_mask", 256'(fq.out_mask_o), 256'(0));
    check_eq("rst_out_pc", 256'(fq.out_pc_o), 256'(0));
    #9 reset = 1'b1;
    @(posedge clk);
    #1;

    // no control transfers, full mask
    drive_bundle(32'h1000, 2'd0, 4'b0000, 8'h00, 4'b0000, 4'b1111, 32'h0);
    step();
    check_eq("c1_mask", 256'(fq.out_mask_o), 256'(4'b1111));
    check_eq("c1_pc", 256'(fq.out_pc_o), 256'(32'h1000));
    check_eq("c1_redirect", 256'(fq.redirect_o), 256'(0));
    drain();

    // offset 2, not-taken conditional then BTB-hit jump; slot 0 ahead of offset ignored
    drive_bundle(32'h3000, 2'd2, 4'b1101, 8'b10_11_00_10, 4'b0000, 4'b1110, 32'h0);
    step();
    check_eq("c2_mask", 256'(fq.out_mask_o), 256'(4'b1100));
    check_eq("c2_redirect", 256'(fq.redirect_o), 256'(0));
    drain();

    // return in slot 1 missing the BTB
    fq.out_ready_i = 1'b0;
    drive_bundle(32'h2000, 2'd0, 4'b0010, 8'h00, 4'b0000, 4'b0000, 32'h4000);
    fq.out_ready_i = 1'b0;
    step();
    check_eq("c3_mask", 256'(fq.out_mask_o), 256'(4'b0011));
    check_eq("c3_target1", 256'(fq.out_target_o[2*SIZE_PC-1:SIZE_PC]), 256'(32'h4000));
    check_eq("c3_redirect", 256'(fq.redirect_o), 256'(1));
    check_eq("c3_rtr", 256'(fq.redirect_rtr_o), 256'(1));
    check_eq("c3_redirect_pc", 256'(fq.redirect_pc_o), 256'(32'h4000));
    check_eq("c3_call_pc", 256'(fq.call_pc_o), 256'(32'h2008));
    drive_bundle(32'h5000, 2'd0, 4'b0000, 8'h00, 4'b0000, 4'b1111, 32'h0);
    step();
    check_eq("c3_dropped_occ", 256'(fq.occupancy_o), 256'(1));
    check_eq("c3_redirect_off", 256'(fq.redirect_o), 256'(0));
    drain();

    // fill, then pop while offering a bundle, across pointer wrap
    for (int k = 0; k < QDEPTH; k++) begin
      drive_bundle(32'h6000 + 32'(k * 32), 2'(k), 4'b0000, 8'h00, 4'b0000, 4'b1111, 32'h0);
      fq.out_ready_i = 1'b0;
      step();
    end
    check_eq("c4_full_occ", 256'(fq.occupancy_o), 256'(QDEPTH));
    check_eq("c4_full_ready", 256'(fq.fs1_ready_o), 256'(0));
    drive_bundle(32'h7000, 2'd1, 4'b0000, 8'h00, 4'b0000, 4'b1111, 32'h0);
    fq.out_ready_i = 1'b1;
    step();
    check_eq("c4_pop_only", 256'(fq.occupancy_o), 256'(QDEPTH - 1));
    step();
    check_eq("c4_push_pop", 256'(fq.occupancy_o), 256'(QDEPTH - 1));
    drain();

    // flush with three entries queued and a redirect outstanding
    for (int k = 0; k < 2; k++) begin
      drive_bundle(32'h8000 + 32'(k * 32), 2'd0, 4'b0000, 8'h00, 4'b0000, 4'b1111, 32'h0);
      fq.out_ready_i = 1'b0;
      step();
    end
    drive_bundle(32'h9000, 2'd0, 4'b0001, 8'b00_00_00_01, 4'b0000, 4'b0000, 32'h0);
    fq.out_ready_i = 1'b0;
    step();
    check_eq("c5_occ", 256'(fq.occupancy_o), 256'(3));
    check_eq("c5_call", 256'(fq.redirect_call_o), 256'(1));
    fq.flush_i = 1'b1;
    step();
    check_eq("c5_flush_occ", 256'(fq.occupancy_o), 256'(0));
    check_eq("c5_flush_valid", 256'(fq.out_valid_o), 256'(0));
    check_eq("c5_flush_redirect", 256'(fq.redirect_o), 256'(0));

    // asynchronous reset between edges
    idle();
    fq.out_ready_i = 1'b0;
    drive_bundle(32'hA000, 2'd0, 4'b0000, 8'h00, 4'b0000, 4'b1111, 32'h0);
    fq.out_ready_i = 1'b0;
    step();
    step();
    idle();
    #1 reset = 1'b0;
    #1;
    check_eq("mid_rst_occ", 256'(fq.occupancy_o), 256'(0));
    check_eq("mid_rst_valid", 256'(fq.out_valid_o), 256'(0));
    check_eq("mid_rst_ready", 256'(fq.fs1_ready_o), 256'(1));
    model_clear();
    #1 reset = 1'b1;
    drive_bundle(32'hB000, 2'd0, 4'b0000, 8'h00, 4'b0000, 4'b1111, 32'h0);
    fq.out_ready_i = 1'b0;
    step();
    check_eq("post_rst_occ", 256'(fq.occupancy_o), 256'(1));
    drain();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [FETCH_WIDTH-1:0] btb;
      for (int i = 0; i < FETCH_WIDTH; i++) btb[i] = ($urandom_range(0, 4) != 0);
      drive_bundle(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : SIZE_PC'($urandom()),
                   SLOT_W'($urandom_range(0, FETCH_WIDTH - 1)), FETCH_WIDTH'($urandom()),
                   (2*FETCH_WIDTH)'($urandom()), FETCH_WIDTH'($urandom()), btb,
                   SIZE_PC'($urandom()));
      fq.fs1_valid_i = ($urandom_range(0, 9) < 8);
      fq.flush_i     = ($urandom_range(0, 19) == 0);
      fq.out_ready_i = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
